// File: rtl/pipe_pkg.sv
// Shared pipeline widths and constants for the instruction fetch slice.
package pipe_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH {inst, pc} entries with push/pop/flush and a
// zeroed head when empty.
module fetch_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  logic [INST_W-1:0]         i_push_inst,
  input  logic [ADDR_W-1:0]         i_push_pc,
  input  logic                      i_pop,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_valid,
  output logic [INST_W-1:0]         o_head_inst,
  output logic [ADDR_W-1:0]         o_head_pc
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [INST_W-1:0]  r_inst [DEPTH];
  logic [ADDR_W-1:0]  r_pc   [DEPTH];
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [PW:0]        r_count;
  logic               w_wr;
  logic               w_rd;

  // Flush wins over any push/pop in the same cycle.
  assign w_wr = i_push & ~i_flush;
  assign w_rd = i_pop  & ~i_flush;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_inst[r_wp] <= i_push_inst;
      r_pc[r_wp]   <= i_push_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_valid     = (r_count != '0);
  assign o_head_inst = o_valid ? r_inst[r_rp] : NOP;
  assign o_head_pc   = o_valid ? r_pc[r_rp]   : '0;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: issues instruction-memory requests, buffers responses in
// fetch_fifo and handles branch redirects.
module if_fetch_queue
  import pipe_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INST_W-1:0]   imem_rdata,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                id_ready,
  output logic                id_valid,
  output logic [INST_W-1:0]   id_inst,
  output logic [ADDR_W-1:0]   id_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_req_addr;
  logic               r_inflight;
  logic [CW-1:0]      w_count;
  logic [CW:0]        w_need;
  logic               w_pop;
  logic               w_push;
  logic               w_req;

  // Slots needed if this request issues: buffered + in flight + new - leaving.
  always_comb begin
    w_need = {1'b0, w_count} + (CW+1)'(r_inflight) + (CW+1)'(1)
             - (CW+1)'(id_valid & id_ready);
    w_req  = ~rst & ~redirect & (w_need <= (CW+1)'(DEPTH));
  end

  assign w_pop     = id_valid & id_ready;
  assign w_push    = r_inflight;
  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
    end else if (redirect) begin
      r_pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc       <= r_pc + 32'd4;
        r_req_addr <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_inst (imem_rdata),
    .i_push_pc   (r_req_addr),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_valid     (id_valid),
    .o_head_inst (id_inst),
    .o_head_pc   (id_pc)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b1;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  int n_total = 0;
  int n_pass  = 0;

  if_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_inst     (id_inst),
    .id_pc       (id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Registered instruction memory; unrequested cycles return junk.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_fn(imem_addr);
    else          imem_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain queue of buffered entries plus one pending fetch.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc       = RESET_PC;
  bit          m_pending  = 0;
  logic [31:0] m_pend_pc  = '0;

  function automatic bit model_req();
    int unsigned pop;
    pop = (mq.size() != 0 && id_ready) ? 1 : 0;
    return !rst && !redirect && (mq.size() + m_pending + 1 - pop <= DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pc = RESET_PC;
      m_pending = 0;
    end else begin
      bit req;
      bit pop;
      req = model_req();
      pop = (mq.size() != 0) && id_ready;
      if (redirect) begin
        mq.delete();
        m_pending = 0;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_pending) mq.push_back('{inst: mem_fn(m_pend_pc), pc: m_pend_pc});
        if (mq.size() > DEPTH) check("overflow", mq.size(), DEPTH);
        m_pending = req;
        if (req) begin
          m_pend_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_req",   {31'b0, imem_req}, 32'd0);
      check("rst_valid", {31'b0, id_valid}, 32'd0);
      check("rst_inst",  id_inst, 32'd0);
      check("rst_pc",    id_pc,   32'd0);
    end else begin
      bit r;
      r = model_req();
      check("req",   {31'b0, imem_req}, {31'b0, r});
      if (r) check("addr", imem_addr, m_pc);
      check("valid", {31'b0, id_valid}, {31'b0, mq.size() != 0});
      check("inst",  id_inst, (mq.size() != 0) ? mq[0].inst : 32'd0);
      check("id_pc", id_pc,   (mq.size() != 0) ? mq[0].pc   : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int nreq;

    // Reset release, free-flowing decode.
    id_ready = 1'b1;
    do_reset();
    @(negedge clk);
    check("s1_req0", {31'b0, imem_req}, 32'd1);
    check("s1_addr0", imem_addr, 32'h0);
    check("s1_val0", {31'b0, id_valid}, 32'd0);
    step(); @(negedge clk);
    check("s1_addr1", imem_addr, 32'h4);
    check("s1_val1", {31'b0, id_valid}, 32'd0);
    step(); @(negedge clk);
    check("s1_addr2", imem_addr, 32'h8);
    check("s1_val2", {31'b0, id_valid}, 32'd1);
    check("s1_pc2", id_pc, 32'h0);
    check("s1_inst2", id_inst, 32'h5A5A_0F0F);
    step(); @(negedge clk);
    check("s1_pc3", id_pc, 32'h4);
    step(); @(negedge clk);
    check("s1_pc4", id_pc, 32'h8);
    step();

    // Stalled decode fills the buffer.
    id_ready = 1'b0;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nreq += imem_req;
      if (i >= 2) check("s2_hold_pc", id_pc, 32'h0);
      step();
    end
    check("s2_nreq", nreq, 32'd4);
    check("s2_req_off", {31'b0, imem_req}, 32'd0);

    // Redirect while full and decode ready.
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    check("s3_req_red", {31'b0, imem_req}, 32'd0);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("s3_val_r1", {31'b0, id_valid}, 32'd0);
    check("s3_addr", imem_addr, 32'h40);
    step(); @(negedge clk);
    check("s3_val_r2", {31'b0, id_valid}, 32'd0);
    step(); @(negedge clk);
    check("s3_val_r3", {31'b0, id_valid}, 32'd1);
    check("s3_pc", id_pc, 32'h40);
    step();

    // Unaligned target is forced to word alignment.
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("s4_addr", imem_addr, 32'h100);
    step();

    // Fetch PC wraps around the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("s5_addr0", imem_addr, 32'hFFFF_FFF8);
    step(); @(negedge clk);
    check("s5_addr1", imem_addr, 32'hFFFF_FFFC);
    step(); @(negedge clk);
    check("s5_addr2", imem_addr, 32'h0000_0000);
    check("s5_req2", {31'b0, imem_req}, 32'd1);
    step();

    // Asynchronous reset with three buffered entries.
    id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    check("s6_val_pre", {31'b0, id_valid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("s6_val_rst", {31'b0, id_valid}, 32'd0);
    check("s6_req_rst", {31'b0, imem_req}, 32'd0);
    step();
    rst = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    check("s6_req_rel", {31'b0, imem_req}, 32'd1);
    check("s6_addr_rel", imem_addr, RESET_PC);
    step();

    // Randomized traffic: phased stall density, redirects, rare resets.
    for (int i = 0; i < 4000; i++) begin
      int unsigned busy;
      busy = ((i / 400) % 2 == 1) ? 8 : 3;
      id_ready = ($urandom_range(0, 9) >= busy);
      redirect = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    redirect = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the instruction buffer entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req  out  1  fetch request valid this cycle.
- imem_addr  out  32  byte address of the fetch; bits [1:0] always 0.
- imem_rdata  in  32  instruction word; valid in the cycle after the imem_req cycle (registered instruction memory, 1-cycle latency).
- redirect  in  1  taken-branch flush request from the MEM-stage branch resolution.
- redirect_pc  in  32  branch target; bits [1:0] ignored and treated as 0.
- id_ready  in  1  decode stage can accept; low while the hazard unit stalls.
- id_valid  out  1  id_inst/id_pc hold a valid instruction.
- id_inst  out  32  head instruction, feeding the IF/ID register.
- id_pc  out  32  byte address of id_inst.

Function
REQ-004 The block SHALL keep a fetch PC register, a buffer of DEPTH {inst, pc} entries, an entry count, and a 1-bit in-flight flag (request issued last cycle, response due this cycle).
REQ-005 imem_req SHALL be 1 when redirect=0 and (count + inflight + 1 - pop) <= DEPTH, where pop = id_valid & id_ready.
REQ-006 imem_addr SHALL equal the fetch PC whenever imem_req=1; on each issued request the fetch PC SHALL advance by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-007 The block SHALL push the response into the buffer, tagged with its request address, at the end of the cycle after the request. The first instruction SHALL reach id_valid=1 two cycles after its request cycle.
REQ-008 id_valid SHALL equal (count != 0). id_inst and id_pc SHALL show the head entry, and SHALL be 0 when the buffer is empty.
REQ-009 When id_valid=1 and id_ready=1, the block SHALL pop the head. With id_ready=0, the head and all outputs SHALL hold stable.
REQ-010 If a push and a pop occur in the same cycle, count SHALL be unchanged. Read and write pointers SHALL wrap modulo DEPTH.
REQ-011 REQ-005 SHALL guarantee no overflow: a response SHALL never arrive while count=DEPTH without a pop in the same cycle.
REQ-012 On redirect=1, the block SHALL at the next edge:
- set count to 0 and reset both pointers;
- discard the in-flight response (clear the in-flight flag without a push);
- ignore any pop in that cycle;
- load the fetch PC with {redirect_pc[31:2], 2'b00}.
REQ-013 imem_req SHALL be 0 in the redirect cycle. The first request at the target SHALL issue in the following cycle.
REQ-014 Redirect SHALL take priority over a simultaneous push, pop and stall.
REQ-015 Back-to-back redirects SHALL each restart fetch, with the last one winning.

Reset
REQ-016 While rst=1, the block SHALL hold: fetch PC=RESET_PC, count=0, pointers=0, in-flight=0, imem_req=0, id_valid=0, id_inst=0, id_pc=0.
REQ-017 On rst deassertion, the first cycle SHALL issue imem_req=1 with imem_addr=RESET_PC.
REQ-018 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions immediately.

Structure
REQ-019 The shared package pipe_pkg SHALL hold INST_W=32, ADDR_W=32, RESET_PC and the NOP encoding 32'h0000_0000.
REQ-020 The buffer SHALL be a sub-module fetch_fifo (storage, pointers, count, push/pop/flush). Request and redirect control SHALL stay in if_fetch_queue.

Verification
REQ-021 Reset release with id_ready=1 held -> requests at 0x0, 0x4, 0x8 on consecutive cycles; id_valid first high 2 cycles after the first request; id_pc follows 0x0, 0x4, 0x8 on successive cycles.
REQ-022 id_ready=0 for 10 cycles from reset release, DEPTH=4 -> exactly 4 requests issued; imem_req=0 thereafter; id_pc=0x0 held stable.
REQ-023 id_ready=0 until full, then redirect=1 with redirect_pc=0x40 while id_ready=1 -> id_valid=0 next cycle; next request at 0x40; next id_pc=0x40; no pre-redirect instruction emerges.
REQ-024 redirect with redirect_pc=0x103 -> fetch resumes at 0x100.
REQ-025 Fetch PC set by redirect to 0xFFFF_FFF8 -> requests at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-026 rst pulsed mid-stream with the buffer holding 3 entries -> id_valid=0 immediately; first request after release at RESET_PC.
